// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared HDLC constants, receiver state type and CRC step helper
package hdlc_pkg;

  localparam logic [7:0]  HDLC_FLAG        = 8'h7E;
  localparam logic [15:0] CRC_POLY_REFL    = 16'h8408;
  localparam logic [15:0] CRC_INIT         = 16'hFFFF;
  localparam logic [15:0] CRC_GOOD_RESIDUE = 16'hF0B8;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    DATA
  } hdlc_state_e;

  // One LSB-first bit through the reflected CRC-16/X.25 register.
  function automatic logic [15:0] crc16_x25_step(input logic [15:0] crc, input logic b);
    crc16_x25_step = (crc >> 1) ^ (((crc[0] ^ b) == 1'b1) ? CRC_POLY_REFL : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_x25_serial.sv
// rtl/crc16_x25_serial.sv - bit-serial CRC-16/X.25 register, shared by the RX deframer and TX framer
module crc16_x25_serial
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        init,
  input  logic        bit_en,
  input  logic        data_bit,
  output logic [15:0] crc
);

  // init wins over bit_en so a flag re-seeds the register even mid-stream.
  always_ff @(posedge clk) begin
    if (init) begin
      crc <= CRC_INIT;
    end else if (bit_en) begin
      crc <= crc16_x25_step(crc, data_bit);
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// rtl/hdlc_rx_deframer.sv - NRZI decode, flag hunt, zero destuff, byte assembly and FCS check
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 330,
  parameter int LEN_W           = 9
) (
  input  logic             i_TXRX_CLOCK,
  input  logic             i_reset,
  input  logic             i_bit_en,
  input  logic             i_rx_bit,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  output logic             o_frame_start,
  output logic             o_frame_end,
  output logic             o_crc_ok,
  output logic             o_frame_err,
  output logic             o_abort,
  output logic [LEN_W-1:0] o_len,
  output logic             o_in_frame
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(3);

  hdlc_state_e      state, state_n;
  logic             prev_line, prev_line_n;
  logic [7:0]       win, win_n;
  logic [3:0]       win_valid, win_valid_n;
  logic [2:0]       ones_run, ones_run_n;
  logic [2:0]       exit_ones, exit_ones_n;
  logic [7:0]       sh, sh_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_n;

  logic [7:0]       byte_n;
  logic             byte_valid_n, frame_start_n, frame_end_n;
  logic             crc_ok_n, frame_err_n, abort_n;
  logic [LEN_W-1:0] len_n;

  logic             d;
  logic             flag_evt, abort_evt, bad_frame;
  logic             crc_bit_en, crc_flag_init;
  logic [15:0]      crc;

  assign d          = (i_rx_bit == prev_line);
  assign o_in_frame = (state == DATA);

  crc16_x25_serial u_crc (
    .clk      (i_TXRX_CLOCK),
    .init     (i_reset | crc_flag_init),
    .bit_en   (crc_bit_en),
    .data_bit (win[0]),
    .crc      (crc)
  );

  always_comb begin
    state_n       = state;
    prev_line_n   = prev_line;
    win_n         = win;
    win_valid_n   = win_valid;
    ones_run_n    = ones_run;
    exit_ones_n   = exit_ones;
    sh_n          = sh;
    bit_cnt_n     = bit_cnt;
    byte_cnt_n    = byte_cnt;
    byte_n        = o_byte;
    byte_valid_n  = 1'b0;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    crc_ok_n      = 1'b0;
    frame_err_n   = 1'b0;
    abort_n       = 1'b0;
    len_n         = '0;
    flag_evt      = 1'b0;
    abort_evt     = 1'b0;
    bad_frame     = 1'b0;
    crc_bit_en    = 1'b0;
    crc_flag_init = 1'b0;

    if (i_bit_en) begin
      prev_line_n = i_rx_bit;
      win_n       = {d, win[7:1]};
      win_valid_n = (win_valid == 4'd8) ? 4'd8 : win_valid + 4'd1;
      ones_run_n  = !d ? 3'd0 : ((ones_run == 3'd7) ? 3'd7 : ones_run + 3'd1);
      flag_evt    = (win == HDLC_FLAG) && (win_valid == 4'd8);
      abort_evt   = d && (ones_run == 3'd6);

      if (flag_evt || abort_evt) begin
        // The bit arriving with a flag already belongs to what follows it.
        win_valid_n = flag_evt ? 4'd1 : 4'd0;
        exit_ones_n = 3'd0;
        bit_cnt_n   = 3'd0;
        byte_cnt_n  = '0;
      end

      if (flag_evt) begin
        crc_flag_init = 1'b1;
        if (state == HUNT) begin
          state_n = SYNC;
        end else if (state == DATA) begin
          state_n = SYNC;
          if (!(byte_cnt == '0 && bit_cnt == 3'd0)) begin
            bad_frame   = (bit_cnt != 3'd0) || (byte_cnt < MIN_LEN);
            frame_end_n = 1'b1;
            len_n       = byte_cnt;
            frame_err_n = bad_frame;
            crc_ok_n    = (crc == CRC_GOOD_RESIDUE) && !bad_frame;
          end
        end
      end else if (abort_evt) begin
        abort_n = (state != HUNT);
        state_n = HUNT;
      end else if (win_valid == 4'd8) begin
        if (!win[0] && exit_ones == 3'd5) begin
          exit_ones_n = 3'd0;
        end else begin
          exit_ones_n = !win[0] ? 3'd0 : ((exit_ones == 3'd7) ? 3'd7 : exit_ones + 3'd1);
          if (state != HUNT) begin
            crc_bit_en = 1'b1;
            state_n    = DATA;
            sh_n       = {win[0], sh[7:1]};
            bit_cnt_n  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == MAX_LEN) begin
                // Overflow: the extra byte is swallowed and the frame closes in error.
                frame_end_n = 1'b1;
                frame_err_n = 1'b1;
                len_n       = MAX_LEN;
                state_n     = HUNT;
                byte_cnt_n  = '0;
              end else begin
                byte_n        = sh_n;
                byte_valid_n  = 1'b1;
                frame_start_n = (byte_cnt == '0);
                byte_cnt_n    = byte_cnt + LEN_W'(1);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_TXRX_CLOCK) begin
    if (i_reset) begin
      state         <= HUNT;
      prev_line     <= 1'b0;
      win           <= '0;
      win_valid     <= '0;
      ones_run      <= '0;
      exit_ones     <= '0;
      sh            <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      o_byte        <= '0;
      o_byte_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_crc_ok      <= 1'b0;
      o_frame_err   <= 1'b0;
      o_abort       <= 1'b0;
      o_len         <= '0;
    end else begin
      state         <= state_n;
      prev_line     <= prev_line_n;
      win           <= win_n;
      win_valid     <= win_valid_n;
      ones_run      <= ones_run_n;
      exit_ones     <= exit_ones_n;
      sh            <= sh_n;
      bit_cnt       <= bit_cnt_n;
      byte_cnt      <= byte_cnt_n;
      o_byte        <= byte_n;
      o_byte_valid  <= byte_valid_n;
      o_frame_start <= frame_start_n;
      o_frame_end   <= frame_end_n;
      o_crc_ok      <= crc_ok_n;
      o_frame_err   <= frame_err_n;
      o_abort       <= abort_n;
      o_len         <= len_n;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb/tb_hdlc_rx_deframer.sv - table-driven and randomized frame checks against a frame-level model
module tb_hdlc_rx_deframer;

  localparam int MAX_FRAME_BYTES = 330;
  localparam int LEN_W           = 9;

  typedef logic [7:0] u8;

  logic             clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_bit_en = 1'b0;
  logic             i_rx_bit = 1'b0;
  logic [7:0]       o_byte;
  logic             o_byte_valid, o_frame_start, o_frame_end;
  logic             o_crc_ok, o_frame_err, o_abort, o_in_frame;
  logic [LEN_W-1:0] o_len;

  always #5 clk = ~clk;

  hdlc_rx_deframer #(.MAX_FRAME_BYTES(MAX_FRAME_BYTES), .LEN_W(LEN_W)) dut (
    .i_TXRX_CLOCK  (clk),
    .i_reset       (i_reset),
    .i_bit_en      (i_bit_en),
    .i_rx_bit      (i_rx_bit),
    .o_byte        (o_byte),
    .o_byte_valid  (o_byte_valid),
    .o_frame_start (o_frame_start),
    .o_frame_end   (o_frame_end),
    .o_crc_ok      (o_crc_ok),
    .o_frame_err   (o_frame_err),
    .o_abort       (o_abort),
    .o_len         (o_len),
    .o_in_frame    (o_in_frame)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Output capture
  typedef struct {
    int len;
    bit ok;
    bit err;
  } end_t;

  u8    cap_bytes[$];
  end_t cap_end[$];
  int   cap_start   = 0;
  int   cap_abort   = 0;
  int   start_bad   = 0;
  int   end_overlap = 0;

  always @(negedge clk) begin
    end_t e;
    if (o_byte_valid) cap_bytes.push_back(o_byte);
    if (o_frame_start) begin
      cap_start++;
      if (!o_byte_valid) start_bad++;
    end
    if (o_frame_end) begin
      e.len = int'(o_len);
      e.ok  = o_crc_ok;
      e.err = o_frame_err;
      cap_end.push_back(e);
      if (o_byte_valid) end_overlap++;
    end
    if (o_abort) cap_abort++;
  end

  // Line-side transmitter model: stuffing and NRZI
  logic line    = 1'b0;
  int   tx_ones = 0;
  bit   gaps_on = 1'b0;

  task automatic tick(input logic en, input logic b);
    @(posedge clk);
    #1;
    i_bit_en = en;
    i_rx_bit = b;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, line);
  endtask

  task automatic send_d(input logic d);
    if (gaps_on && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) tick(1'b0, 1'($urandom_range(0, 1)));
    if (!d) line = ~line;
    tick(1'b1, line);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_d(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_dbit(input logic b);
    send_d(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_d(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input u8 b);
    for (int i = 0; i < 8; i++) send_dbit(b[i]);
  endtask

  function automatic logic [15:0] fcs_of(input u8 q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < q.size(); i++) begin
      c = c ^ {8'h00, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic run_frame(input string name, input u8 pl[$], input bit add_fcs, input int flip,
                           input bit gaps, input int exp_len, input bit exp_ok, input bit exp_err);
    u8           body[$];
    logic [15:0] fcs;
    int          b0, e0, s0, a0, nexp, bad;
    body = pl;
    if (add_fcs) begin
      fcs = fcs_of(pl);
      body.push_back(fcs[7:0]);
      body.push_back(fcs[15:8]);
    end
    if (flip >= 0) body[flip / 8] = body[flip / 8] ^ u8'(1 << (flip % 8));
    nexp = (body.size() > MAX_FRAME_BYTES) ? MAX_FRAME_BYTES : body.size();
    b0 = cap_bytes.size();
    e0 = cap_end.size();
    s0 = cap_start;
    a0 = cap_abort;
    gaps_on = gaps;
    repeat (3) send_flag();
    foreach (body[i]) send_byte(body[i]);
    repeat (2) send_flag();
    gaps_on = 1'b0;
    idle(4);
    check({name, ".nbytes"}, cap_bytes.size() - b0, nexp);
    bad = 0;
    for (int i = 0; i < nexp && b0 + i < cap_bytes.size(); i++)
      if (cap_bytes[b0 + i] !== body[i]) bad++;
    check({name, ".byte_errs"}, bad, 0);
    check({name, ".frame_ends"}, cap_end.size() - e0, 1);
    if (cap_end.size() > e0) begin
      check({name, ".len"}, cap_end[e0].len, exp_len);
      check({name, ".crc_ok"}, int'(cap_end[e0].ok), int'(exp_ok));
      check({name, ".frame_err"}, int'(cap_end[e0].err), int'(exp_err));
    end
    check({name, ".starts"}, cap_start - s0, 1);
    check({name, ".aborts"}, cap_abort - a0, 0);
  endtask

  typedef struct {
    string name;
    int    kind;     // 0 "123456789", 1 FF FF 7E, 2 12 34, 3 random
    int    nbytes;
    bit    add_fcs;
    int    flip;
    bit    gaps;
    int    exp_len;
    bit    exp_ok;
    bit    exp_err;
  } vec_t;

  function automatic void make_payload(input int kind, input int n, output u8 q[$]);
    q = {};
    case (kind)
      0: for (int i = 0; i < 9; i++) q.push_back(u8'(8'h31 + i));
      1: q = '{8'hFF, 8'hFF, 8'h7E};
      2: q = '{8'h12, 8'h34};
      default: for (int i = 0; i < n; i++) q.push_back(u8'($urandom_range(0, 255)));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    u8    pl[$];
    int   b0, e0, s0, a0, n, flip;
    bit   corrupt, gaps;

    vecs[0] = '{"nominal",   0, 9,   1'b1, -1, 1'b0, 11,  1'b1, 1'b0};
    vecs[1] = '{"stuffing",  1, 3,   1'b1, -1, 1'b0, 5,   1'b1, 1'b0};
    vecs[2] = '{"corrupt",   0, 9,   1'b1, 19, 1'b0, 11,  1'b0, 1'b0};
    vecs[3] = '{"en_gaps",   0, 9,   1'b1, -1, 1'b1, 11,  1'b1, 1'b0};
    vecs[4] = '{"two_byte",  2, 2,   1'b0, -1, 1'b0, 2,   1'b0, 1'b1};
    vecs[5] = '{"max_len",   3, 328, 1'b1, -1, 1'b0, 330, 1'b1, 1'b0};
    vecs[6] = '{"overflow",  3, 331, 1'b0, -1, 1'b0, 330, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({o_byte, o_byte_valid, o_frame_start, o_frame_end, o_crc_ok,
                                 o_frame_err, o_abort, o_len, o_in_frame}), 0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      make_payload(vecs[v].kind, vecs[v].nbytes, pl);
      run_frame(vecs[v].name, pl, vecs[v].add_fcs, vecs[v].flip, vecs[v].gaps,
                vecs[v].exp_len, vecs[v].exp_ok, vecs[v].exp_err);
    end

    // Idle flags only
    b0 = cap_bytes.size(); e0 = cap_end.size(); s0 = cap_start; a0 = cap_abort;
    repeat (6) send_flag();
    idle(4);
    check("flags_only.strobes", (cap_bytes.size() - b0) + (cap_end.size() - e0)
                                + (cap_start - s0) + (cap_abort - a0), 0);

    // 13 data bits between flags
    b0 = cap_bytes.size(); e0 = cap_end.size();
    repeat (3) send_flag();
    send_byte(8'hA5);
    send_dbit(1'b1); send_dbit(1'b0); send_dbit(1'b1); send_dbit(1'b1); send_dbit(1'b0);
    repeat (2) send_flag();
    idle(4);
    check("misalign.nbytes", cap_bytes.size() - b0, 1);
    if (cap_bytes.size() > b0) check("misalign.byte", int'(cap_bytes[b0]), 'hA5);
    check("misalign.frame_ends", cap_end.size() - e0, 1);
    if (cap_end.size() > e0) begin
      check("misalign.len", cap_end[e0].len, 1);
      check("misalign.frame_err", int'(cap_end[e0].err), 1);
      check("misalign.crc_ok", int'(cap_end[e0].ok), 0);
    end

    // Abort after 4 bytes: the 7th one lands before byte 4's last bit leaves the window
    b0 = cap_bytes.size(); e0 = cap_end.size(); a0 = cap_abort;
    repeat (3) send_flag();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (8) send_d(1'b1);
    repeat (3) send_flag();
    idle(4);
    check("abort.pulses", cap_abort - a0, 1);
    check("abort.frame_ends", cap_end.size() - e0, 0);
    check("abort.nbytes", cap_bytes.size() - b0, 3);
    make_payload(0, 9, pl);
    run_frame("after_abort", pl, 1'b1, -1, 1'b0, 11, 1'b1, 1'b0);

    // Reset after byte 5 of a frame
    e0 = cap_end.size(); a0 = cap_abort;
    repeat (3) send_flag();
    for (int i = 0; i < 5; i++) send_byte(u8'(8'h31 + i));
    @(negedge clk);
    check("midreset.in_frame_before", int'(o_in_frame), 1);
    @(posedge clk);
    #1;
    i_reset  = 1'b1;
    i_bit_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset.outputs", int'({o_byte, o_byte_valid, o_frame_start, o_frame_end, o_crc_ok,
                                    o_frame_err, o_abort, o_len, o_in_frame}), 0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    line    = 1'b0;
    repeat (3) send_flag();
    idle(4);
    check("midreset.frame_ends", cap_end.size() - e0, 0);
    check("midreset.aborts", cap_abort - a0, 0);
    run_frame("after_reset", pl, 1'b1, -1, 1'b0, 11, 1'b1, 1'b0);

    // Randomized frames against the frame-level rules
    for (int r = 0; r < 6; r++) begin
      n       = $urandom_range(1, 40);
      corrupt = 1'($urandom_range(0, 1));
      gaps    = 1'($urandom_range(0, 1));
      flip    = corrupt ? int'($urandom_range(0, n * 8 - 1)) : -1;
      make_payload(3, n, pl);
      run_frame($sformatf("rand%0d", r), pl, 1'b1, flip, gaps, n + 2, !corrupt, 1'b0);
    end

    check("start_with_byte", start_bad, 0);
    check("end_after_last_byte", end_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
